// File: rtl/vram_arbiter.sv
// Shares the single-port VRAM between VGA scan-out, the CPU window and a fill engine.
// Fixed priority VGA > CPU > clear; a starved clear engine gets one slot ahead of the CPU.
module vram_arbiter #(
    parameter int AW         = 19,
    parameter int DW         = 12,
    parameter int DEPTH      = 307200,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vga_req,
    input  logic [AW-1:0] vga_addr,
    output logic [DW-1:0] vga_rdata,
    output logic          vga_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          clear_start,
    input  logic [DW-1:0] clear_color,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [AW-1:0] vram_addr,
    output logic          vram_we,
    output logic [DW-1:0] vram_wdata,
    input  logic [DW-1:0] vram_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t        r_state;
    logic [AW-1:0] r_ptr;
    logic [DW-1:0] r_color;
    logic [SW-1:0] r_starve;
    logic          r_done;
    logic          r_vga_rvalid_p1;
    logic          r_cpu_rvalid_p1;

    logic w_clear;
    logic w_force_clr;
    logic w_vga_own;
    logic w_cpu_gnt;
    logic w_clr_wr;
    logic w_last;

    assign w_clear     = (r_state == S_CLEAR);
    assign w_force_clr = w_clear && (r_starve == SW'(STARVE_MAX));
    assign w_last      = (r_ptr == AW'(DEPTH - 1));

    // Grants are suppressed while rst is high so an aborted fill leaves no extra write behind.
    assign w_vga_own = !rst && vga_req;
    assign w_cpu_gnt = !rst && !vga_req && cpu_req && !w_force_clr;
    assign w_clr_wr  = !rst && !vga_req && !w_cpu_gnt && w_clear;

    always_comb begin
        vram_addr  = '0;
        vram_we    = 1'b0;
        vram_wdata = '0;
        if (w_vga_own) begin
            vram_addr = vga_addr;
        end else if (w_cpu_gnt) begin
            vram_addr  = cpu_addr;
            vram_we    = cpu_we;
            vram_wdata = cpu_wdata;
        end else if (w_clr_wr) begin
            vram_addr  = r_ptr;
            vram_we    = 1'b1;
            vram_wdata = r_color;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_starve        <= '0;
            r_done          <= 1'b0;
            r_vga_rvalid_p1 <= 1'b0;
            r_cpu_rvalid_p1 <= 1'b0;
        end else begin
            // ---- read return stage: VRAM answers one cycle after the grant ----
            r_vga_rvalid_p1 <= vga_req;
            r_cpu_rvalid_p1 <= w_cpu_gnt && !cpu_we;
            r_done          <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear_start) begin
                        r_color  <= clear_color;
                        r_ptr    <= '0;
                        r_starve <= '0;
                        r_state  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (w_clr_wr) begin
                        r_starve <= '0;
                        if (w_last) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end else if (r_starve != SW'(STARVE_MAX)) begin
                        r_starve <= r_starve + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_gnt    = w_cpu_gnt;
    assign cpu_stall  = cpu_req && !w_cpu_gnt;
    assign vga_rvalid = r_vga_rvalid_p1;
    assign cpu_rvalid = r_cpu_rvalid_p1;
    // Read data is zeroed outside its valid cycle so every output idles at 0.
    assign vga_rdata  = r_vga_rvalid_p1 ? vram_rdata : '0;
    assign cpu_rdata  = r_cpu_rvalid_p1 ? vram_rdata : '0;
    assign clear_busy = w_clear;
    assign clear_done = r_done;

endmodule
